frame_scan_rd: RTL

FRAME_SCAN_RD -- requirements
Module: frame_scan_rd

---
 rtl/frame_scan_rd.sv | 96 +++++++++
 1 files changed

// File: rtl/frame_scan_rd.sv
// frame_scan_rd: raster-order 7x7 window reader with credit-limited requests and an output window FIFO.
// Every issued tag is queued until its fixed-latency memory return, then stored alongside the pixel data.
module frame_scan_rd #(
   parameter int ROWS       = 128,
   parameter int COLS       = 128,
   parameter int MEM_LAT    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         clk_en_r,
   output logic [6:0]   row_r,
   output logic [6:0]   col_r,
   output logic         addr_r_valid,
   input  logic [489:0] pixel_r,
   input  logic         pixel_r_valid,
   output logic [489:0] win_data,
   output logic [6:0]   win_row,
   output logic [6:0]   win_col,
   output logic         win_last,
   output logic         win_valid,
   input  logic         win_ready,
   output logic         err_unexp
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
   localparam logic [13:0] LAST_TAG = {7'(ROWS - 1), 7'(COLS - 1)};
   logic [1:0]      state;
   logic [CW-1:0]   fcnt, infl, widx;
   logic [PW-1:0]   wp, rp;
   logic [489:0]    fdata [FIFO_DEPTH];
   logic [13:0]     ftag [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] flast;
   logic [13:0]     tq [MEM_LAT];
   logic            go, issue, ret, unexp, pop, fin, last_rc;
   assign go           = start && state == IDLE;
   // credits: every slot already reserved by the FIFO or by an in-flight read blocks a new request
   assign issue        = state == SCAN && ({1'b0, fcnt} + {1'b0, infl}) < (CW + 1)'(FIFO_DEPTH);
   assign addr_r_valid = issue;
   assign ret          = pixel_r_valid && infl != '0;
   assign unexp        = pixel_r_valid && infl == '0;
   assign win_valid    = fcnt != '0;
   assign pop          = win_valid && win_ready;
   assign widx         = infl - CW'(ret);
   assign last_rc      = row_r == 7'(ROWS - 1) && col_r == 7'(COLS - 1);
   // look ahead on the final pop so done follows the last accept by one cycle
   assign fin          = infl == '0 && (fcnt == '0 || (fcnt == CW'(1) && pop));
   assign busy         = state != IDLE;
   assign clk_en_r     = busy;
   assign done         = state == DONE;
   assign win_data     = win_valid ? fdata[rp] : '0;
   assign win_row      = win_valid ? ftag[rp][13:7] : '0;
   assign win_col      = win_valid ? ftag[rp][6:0] : '0;
   assign win_last     = win_valid && flast[rp];
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fcnt      <= '0;
         infl      <= '0;
         wp        <= '0;
         rp        <= '0;
         row_r     <= '0;
         col_r     <= '0;
         err_unexp <= 1'b0;
      end else begin
         state     <= state == IDLE ? (start ? SCAN : IDLE) :
                      state == SCAN ? (issue && last_rc ? DRAIN : SCAN) :
                      state == DRAIN ? (fin ? DONE : DRAIN) : IDLE;
         infl      <= infl + CW'(issue) - CW'(ret);
         fcnt      <= fcnt + CW'(ret) - CW'(pop);
         wp        <= wp + PW'(ret);
         rp        <= rp + PW'(pop);
         err_unexp <= (err_unexp && !go) || unexp;
         if (go) begin
            row_r <= '0;
            col_r <= '0;
         end else if (issue) begin
            col_r <= col_r == 7'(COLS - 1) ? 7'd0 : col_r + 7'd1;
            row_r <= col_r != 7'(COLS - 1) ? row_r : row_r == 7'(ROWS - 1) ? 7'd0 : row_r + 7'd1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (ret) begin
         fdata[wp] <= pixel_r;
         ftag[wp]  <= tq[0];
         flast[wp] <= tq[0] == LAST_TAG;
      end
      for (int i = 0; i < MEM_LAT; i++)
         tq[i] <= issue && widx == CW'(i) ? {row_r, col_r} : ret ? tq[(i + 1) % MEM_LAT] : tq[i];
   end
endmodule
